// File: rtl/vr_vc_converter.sv
// Valid/ready to valid/credit link driver: a small FIFO absorbs upstream beats while
// the downstream credit count is zero. Optional macro VR_VC_BYPASS_EN lets a beat skip the empty FIFO.
module vr_vc_converter #(
   parameter int DATA_WIDTH = 8,
   parameter int CREDIT_NUM = 2,
   parameter int BUF_DEPTH  = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         s_data_i,
   input  logic                          s_valid_i,
   output logic                          s_ready_o,
   output logic [DATA_WIDTH-1:0]         m_data_o,
   output logic                          m_valid_o,
   input  logic                          m_credit_i,
   output logic [$clog2(CREDIT_NUM):0]   credit_cnt_o,
   output logic                          credit_ovf_o
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = $clog2(CREDIT_NUM) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDIT_NUM);

   logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];

   logic [PTR_W:0]        wr_ptr_reg, wr_ptr_next;
   logic [PTR_W:0]        rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]      credit_cnt_reg, credit_cnt_next;
   logic                  credit_ovf_reg, credit_ovf_next;
   logic                  m_valid_reg;
   logic [DATA_WIDTH-1:0] m_data_reg;

   logic                  buf_full, buf_empty, has_credit;
   logic                  push, pop, bypass, launch, wr_en;
   logic [DATA_WIDTH-1:0] launch_data;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign buf_full   = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                       (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
   assign buf_empty  = (wr_ptr_reg == rd_ptr_reg);
   assign has_credit = (credit_cnt_reg != '0);

   assign s_ready_o  = ~buf_full;
   assign push       = s_valid_i & s_ready_o;
   assign pop        = ~buf_empty & has_credit;

`ifdef VR_VC_BYPASS_EN
   assign bypass     = push & buf_empty & has_credit;
`else
   assign bypass     = 1'b0;
`endif

   assign launch      = pop | bypass;
   assign wr_en       = push & ~bypass;
   assign launch_data = bypass ? s_data_i : mem[rd_ptr_reg[PTR_W-1:0]];

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      if (wr_en) begin
         wr_ptr_next = wr_ptr_reg + (PTR_W+1)'(1);
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + (PTR_W+1)'(1);
      end
   end

   // A return that coincides with a launch cancels out; a return at full count saturates and flags.
   always_comb begin
      credit_cnt_next = credit_cnt_reg;
      credit_ovf_next = credit_ovf_reg;
      case ({m_credit_i, launch})
         2'b10: begin
            if (credit_cnt_reg == CNT_MAX) begin
               credit_ovf_next = 1'b1;
            end else begin
               credit_cnt_next = credit_cnt_reg + CNT_W'(1);
            end
         end
         2'b01:   credit_cnt_next = credit_cnt_reg - CNT_W'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_reg[PTR_W-1:0]] <= s_data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         credit_cnt_reg <= '0;
         credit_ovf_reg <= 1'b0;
         m_valid_reg    <= 1'b0;
         m_data_reg     <= '0;
      end else begin
         wr_ptr_reg     <= wr_ptr_next;
         rd_ptr_reg     <= rd_ptr_next;
         credit_cnt_reg <= credit_cnt_next;
         credit_ovf_reg <= credit_ovf_next;
         m_valid_reg    <= launch;
         if (launch) begin
            m_data_reg <= launch_data;
         end
      end
   end

   assign m_valid_o    = m_valid_reg;
   assign m_data_o     = m_data_reg;
   assign credit_cnt_o = credit_cnt_reg;
   assign credit_ovf_o = credit_ovf_reg;

endmodule
